// File: rtl/c64_bus_pkg.sv
// c64_bus_pkg: shared encodings for color_clk-domain C64 expansion-port bus logic
package c64_bus_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, XFER, COOL} dma_state_t;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic REQ_DEBUG = 1'b0;
  localparam logic REQ_LOADER = 1'b1;
  function automatic logic [1:0] req_bit(input logic id);
    return (id == REQ_LOADER) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/phi2_edge.sv
// phi2_edge: registers phi2 and derives single color_clk-cycle rise/fall strobes
module phi2_edge (
  input  logic color_clk,
  input  logic i_phi2,
  output logic o_rise,
  output logic o_fall
);
  logic r_phi2_q;
  // Follows phi2 through reset as well, so no false edge fires when reset releases
  always_ff @(posedge color_clk) r_phi2_q <= i_phi2;
  assign o_rise = i_phi2 & ~r_phi2_q;
  assign o_fall = ~i_phi2 & r_phi2_q;
endmodule

// File: rtl/c64_dma_arbiter.sv
// c64_dma_arbiter: round-robin DMA access for the debug monitor and loader, sequenced to phi2
module c64_dma_arbiter
  import c64_bus_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int STALL_MAX = 255,
  parameter int CW = 8
) (
  input  logic        color_clk,
  input  logic        reset,
  input  logic        i_phi2,
  input  logic        i_ba,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_addr0,
  input  logic [15:0] i_addr1,
  input  logic [1:0]  i_we,
  input  logic [7:0]  i_wdata0,
  input  logic [7:0]  i_wdata1,
  input  logic [7:0]  i_bus_di,
  output logic [1:0]  o_ack,
  output logic        o_err,
  output logic [7:0]  o_rdata,
  output logic        o_dma,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_do,
  output logic        o_bus_rw,
  output logic        o_busy,
  output logic        o_grant_id
);
  dma_state_t r_state;
  logic r_last, r_grant, r_dma, r_rw, r_err;
  logic [1:0] r_ack;
  logic [7:0] r_rdata, r_bus_do;
  logic [15:0] r_bus_addr;
  logic [CW-1:0] r_stall, r_burst;
  logic w_rise, w_fall, w_sel, w_load;
  logic [1:0] w_cand;
  logic [CW-1:0] w_stall_nx, w_burst_nx;

  phi2_edge u_phi2_edge (
    .color_clk(color_clk),
    .i_phi2(i_phi2),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  // Arbitration: in XFER the requester just served is excluded because its req is still high this cycle
  always_comb begin
    w_cand = (r_state == XFER) ? (i_req & ~req_bit(r_grant)) : i_req;
    w_sel = (w_cand[0] & w_cand[1]) ? ~r_last : w_cand[1];
    w_stall_nx = r_stall + CW'(1);
    w_burst_nx = r_burst + CW'(1);
    w_load = (|w_cand) && (((r_state == IDLE) && w_rise && i_ba) ||
                           ((r_state == XFER) && w_fall && (w_burst_nx < CW'(MAX_BURST))));
  end

  // DMA sequencer: latch a transfer, wait out the CPU cycle and BA stalls, move one byte, release
  always_ff @(posedge color_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= REQ_LOADER;
      r_grant <= REQ_DEBUG;
      r_dma <= 1'b0;
      r_rw <= RW_READ;
      r_err <= 1'b0;
      r_ack <= '0;
      r_rdata <= '0;
      r_bus_do <= '0;
      r_bus_addr <= '0;
      r_stall <= '0;
      r_burst <= '0;
    end else begin
      r_ack <= '0;
      r_err <= 1'b0;
      if (w_load) begin
        r_bus_addr <= w_sel ? i_addr1 : i_addr0;
        r_bus_do <= w_sel ? i_wdata1 : i_wdata0;
        r_rw <= i_we[w_sel] ? RW_WRITE : RW_READ;
        r_grant <= w_sel;
        r_last <= w_sel;
        r_stall <= '0;
        r_dma <= 1'b1;
        r_state <= HOLD;
      end
      case (r_state)
        IDLE: r_burst <= '0;
        HOLD: if (w_rise) begin
          if (i_ba) r_state <= XFER;
          else begin
            r_stall <= w_stall_nx;
            if (w_stall_nx == CW'(STALL_MAX)) begin
              r_ack <= req_bit(r_grant);
              r_err <= 1'b1;
              r_dma <= 1'b0;
              r_state <= COOL;
            end
          end
        end
        XFER: if (w_fall) begin
          if (r_rw == RW_READ) r_rdata <= i_bus_di;
          r_ack <= req_bit(r_grant);
          r_burst <= w_load ? w_burst_nx : '0;
          if (!w_load) begin
            r_dma <= 1'b0;
            r_state <= COOL;
          end
        end
        COOL: if (w_rise) r_state <= IDLE;
      endcase
    end
  end

  assign o_ack = r_ack;
  assign o_err = r_err;
  assign o_rdata = r_rdata;
  assign o_dma = r_dma;
  assign o_bus_addr = r_bus_addr;
  assign o_bus_do = r_bus_do;
  assign o_bus_rw = r_rw;
  assign o_busy = (r_state != IDLE);
  assign o_grant_id = r_grant;
endmodule

// File: tb/tb_c64_dma_arbiter.sv
// tb_c64_dma_arbiter: scoreboard bench with a transaction-level round-robin/phi2 reference model
module tb_c64_dma_arbiter;
  localparam int MAXB = 8;
  localparam int SMAX = 4;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } xfer_t;

  typedef struct {
    logic        id;
    logic        err;
    logic [7:0]  rdata;
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  dout;
    int          rises;
  } exp_t;

  logic color_clk = 1'b0, reset = 1'b1, phi2 = 1'b0, ba = 1'b1;
  logic [1:0] req = '0, we = '0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic [7:0] bus_di;
  logic [1:0] ack;
  logic err, dma, bus_rw, busy, grant_id;
  logic [7:0] rdata, bus_do;
  logic [15:0] bus_addr;

  logic [7:0] mem [256];
  xfer_t pend0[$], pend1[$];
  exp_t sb[$];
  int win_q[$];
  int checks = 0, errors = 0;
  logic m_last = 1'b1;
  logic [7:0] m_rdata = '0;

  logic mon_phi2 = 1'b0, mon_dma = 1'b0, mon_rw = 1'b1, mon_grant = 1'b0, mon_gap_ok = 1'b0;
  logic [15:0] mon_addr = '0;
  logic [7:0] mon_do = '0;
  int mon_rises = 0, mon_gap = 0, mon_win = 0;
  exp_t mon_e;

  xfer_t x, x0, x1;
  logic first, id;
  int mode;

  // The memory answers whatever address the arbiter drives
  assign bus_di = mem[bus_addr[7:0]];

  c64_dma_arbiter #(.MAX_BURST(MAXB), .STALL_MAX(SMAX), .CW(8)) dut (
    .color_clk(color_clk), .reset(reset), .i_phi2(phi2), .i_ba(ba), .i_req(req),
    .i_addr0(addr0), .i_addr1(addr1), .i_we(we), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_bus_di(bus_di), .o_ack(ack), .o_err(err), .o_rdata(rdata), .o_dma(dma),
    .o_bus_addr(bus_addr), .o_bus_do(bus_do), .o_bus_rw(bus_rw), .o_busy(busy),
    .o_grant_id(grant_id)
  );

  always #5 color_clk = ~color_clk;

  // phi2: 4 color_clk cycles high, 4 low, changing just after a clock edge
  initial forever begin
    repeat (4) @(posedge color_clk);
    #1 phi2 = ~phi2;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int i);
    if (i == 0) begin
      if (pend0.size() > 0) begin
        addr0 = pend0[0].addr; we[0] = pend0[0].we; wdata0 = pend0[0].wdata; req[0] = 1'b1;
      end else req[0] = 1'b0;
    end else begin
      if (pend1.size() > 0) begin
        addr1 = pend1[0].addr; we[1] = pend1[0].we; wdata1 = pend1[0].wdata; req[1] = 1'b1;
      end else req[1] = 1'b0;
    end
  endtask

  function automatic xfer_t rnd_x();
    xfer_t r;
    r.addr = 16'($urandom);
    r.we = 1'($urandom_range(0, 1));
    r.wdata = 8'($urandom);
    return r;
  endfunction

  // Reference model: each granted transfer either reads mem[addr] or leaves rdata alone
  task automatic expect_xfer(input logic rid, input xfer_t t, input logic e_err, input int rises);
    exp_t e;
    if (!e_err && !t.we) m_rdata = mem[t.addr[7:0]];
    e.id = rid; e.err = e_err; e.rdata = m_rdata; e.addr = t.addr;
    e.rw = ~t.we; e.dout = t.wdata; e.rises = rises;
    sb.push_back(e);
    m_last = rid;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_dma"}, 32'(dma), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_do"}, 32'(bus_do), 32'd0);
    chk({tag, "_bus_rw"}, 32'(bus_rw), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sb.size() != 0 || busy || req != 2'b00) && n < 3000) begin
      @(negedge color_clk);
      n++;
    end
    chk({name, "_completes"}, 32'(n < 3000), 32'd1);
    if (n >= 3000) begin
      sb.delete(); pend0.delete(); pend1.delete(); req = '0;
    end
  endtask

  task automatic wait_dma(input string name);
    int n = 0;
    while (!dma && n < 500) begin
      @(negedge color_clk);
      n++;
    end
    chk({name, "_dma_up"}, 32'(n < 500), 32'd1);
  endtask

  task automatic wait_rises(input int k);
    int c = 0;
    logic p = phi2;
    while (c < k) begin
      @(negedge color_clk);
      if (phi2 && !p) c++;
      p = phi2;
    end
  endtask

  // Monitor: pops the scoreboard on every ack; bus fields are taken from the cycle before the ack
  initial forever begin
    @(negedge color_clk);
    if (reset) begin
      mon_rises = 0; mon_gap = 0; mon_win = 0; mon_gap_ok = 1'b0;
    end else begin
      if (dma && !mon_dma) begin
        if (mon_gap_ok) chk("cpu_gap_rises_ge2", 32'(mon_gap >= 2), 32'd1);
        mon_rises = 0;
        mon_win = 0;
      end
      if (phi2 && !mon_phi2) begin
        if (dma) mon_rises++;
        else mon_gap++;
      end
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got %b, expected no ack", ack);
        end else begin
          mon_e = sb.pop_front();
          chk("ack", 32'(ack), mon_e.id ? 32'd2 : 32'd1);
          chk("err", 32'(err), 32'(mon_e.err));
          chk("rdata", 32'(rdata), 32'(mon_e.rdata));
          chk("bus_addr", 32'(mon_addr), 32'(mon_e.addr));
          chk("bus_rw", 32'(mon_rw), 32'(mon_e.rw));
          chk("bus_do", 32'(mon_do), 32'(mon_e.dout));
          chk("grant_id", 32'(mon_grant), 32'(mon_e.id));
          chk("busy_at_ack", 32'(busy), 32'd1);
          chk("phi2_rises_to_ack", 32'(mon_rises), 32'(mon_e.rises));
        end
        mon_win++;
        mon_rises = 0;
      end
      if (!dma && mon_dma) begin
        win_q.push_back(mon_win);
        mon_gap = 0;
        mon_gap_ok = 1'b1;
      end
    end
    mon_phi2 = phi2; mon_dma = dma; mon_rw = bus_rw; mon_grant = grant_id;
    mon_addr = bus_addr; mon_do = bus_do;
  end

  // Requesters drop req (or present their next transfer) the cycle after their ack
  initial forever begin
    @(negedge color_clk);
    if (!reset && ack[0] && pend0.size() > 0) begin pend0.delete(0); apply(0); end
    if (!reset && ack[1] && pend1.size() > 0) begin pend1.delete(0); apply(1); end
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h0E;
    repeat (3) @(negedge color_clk);
    check_reset("por");
    @(posedge color_clk);
    #1 reset = 1'b0;
    @(negedge color_clk);

    x = '{16'hD020, 1'b0, 8'h00};
    pend0.push_back(x); expect_xfer(1'b0, x, 1'b0, 1); apply(0);
    wait_idle("single_read");
    chk("single_read_rdata", 32'(rdata), 32'h0E);

    x = '{16'h0801, 1'b1, 8'hA9};
    pend1.push_back(x); expect_xfer(1'b1, x, 1'b0, 1); apply(1);
    wait_idle("single_write");

    for (int it = 0; it < 24; it++) begin
      mode = int'($urandom_range(0, 2));
      repeat ($urandom_range(0, 12)) @(negedge color_clk);
      if (mode < 2) begin
        x = rnd_x();
        id = 1'(mode);
        if (id) pend1.push_back(x); else pend0.push_back(x);
        expect_xfer(id, x, 1'b0, 1);
        apply(mode);
      end else begin
        x0 = rnd_x(); x1 = rnd_x();
        first = ~m_last;
        pend0.push_back(x0); pend1.push_back(x1);
        expect_xfer(first, first ? x1 : x0, 1'b0, 1);
        expect_xfer(~first, first ? x0 : x1, 1'b0, 1);
        apply(0); apply(1);
      end
      wait_idle("random");
    end

    win_q.delete();
    for (int k = 0; k < MAXB; k++) begin
      pend0.push_back(rnd_x());
      pend1.push_back(rnd_x());
    end
    first = ~m_last;
    for (int k = 0; k < 2 * MAXB; k++) begin
      id = first ^ 1'(k % 2);
      expect_xfer(id, id ? pend1[k / 2] : pend0[k / 2], 1'b0, 1);
    end
    apply(0); apply(1);
    wait_idle("burst");
    chk("burst_windows", 32'(win_q.size()), 32'd2);
    chk("burst_len0", 32'(win_q.size() > 0 ? win_q[0] : -1), 32'(MAXB));
    chk("burst_len1", 32'(win_q.size() > 1 ? win_q[1] : -1), 32'(MAXB));

    x = rnd_x(); x.we = 1'b0;
    pend0.push_back(x); expect_xfer(1'b0, x, 1'b0, 4); apply(0);
    wait_dma("stall");
    ba = 1'b0;
    wait_rises(3);
    @(negedge color_clk);
    ba = 1'b1;
    wait_idle("stall");

    x = rnd_x();
    pend1.push_back(x); expect_xfer(1'b1, x, 1'b1, SMAX); apply(1);
    wait_dma("timeout");
    ba = 1'b0;
    wait_idle("timeout");
    ba = 1'b1;
    x = rnd_x(); x.we = 1'b0;
    pend1.push_back(x); expect_xfer(1'b1, x, 1'b0, 1); apply(1);
    wait_idle("after_timeout");

    x = rnd_x(); x.we = 1'b0;
    pend0.push_back(x); apply(0);
    wait_dma("xfer_reset");
    wait_rises(1);
    @(negedge color_clk);
    reset = 1'b1;
    pend0.delete();
    req = '0;
    @(negedge color_clk);
    check_reset("xfer_reset");
    m_last = 1'b1;
    m_rdata = '0;
    @(posedge color_clk);
    #1 reset = 1'b0;
    @(negedge color_clk);
    x0 = rnd_x(); x1 = rnd_x();
    pend0.push_back(x0); pend1.push_back(x1);
    expect_xfer(1'b0, x0, 1'b0, 1);
    expect_xfer(1'b1, x1, 1'b0, 1);
    apply(0); apply(1);
    wait_idle("post_reset");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
